// File: rtl/irrigation_sequencer_if.sv
// Signal bundle between the irrigation prerequisite logic, the sequencer and
// the actuator drivers. The sequencer attaches through the slave modport.
interface irrigation_sequencer_if;
  logic       tick;
  logic       irrigation_ok;
  logic       water_sensor_conflicting;
  logic       sprinkler_mode;
  logic       valve_open;
  logic       dripper_on;
  logic       sprinkler_on;
  logic       busy;
  logic       fault;
  logic [2:0] state;

  modport master (
    output tick, irrigation_ok, water_sensor_conflicting, sprinkler_mode,
    input  valve_open, dripper_on, sprinkler_on, busy, fault, state
  );

  modport slave (
    input  tick, irrigation_ok, water_sensor_conflicting, sprinkler_mode,
    output valve_open, dripper_on, sprinkler_on, busy, fault, state
  );
endinterface

// File: rtl/irrigation_sequencer.sv
// Irrigation actuator sequencer: debounces the irrigation permission, opens
// the supply valve and lets it settle, runs the dripper or sprinkler, then
// closes, drains and cools down. A water sensor conflict forces an all-off
// fault state from anywhere.
// Optional feature: define IRRIGATION_RUN_TIMEOUT_EN to end a run after
// MAX_RUN_TICKS ticks even while the permission is still present.
module irrigation_sequencer #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int SETTLE_TICKS   = 2,
  parameter int MAX_RUN_TICKS  = 60,
  parameter int COOLDOWN_TICKS = 10,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  irrigation_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_QUALIFY  = 3'd1,
    S_OPEN     = 3'd2,
    S_RUN      = 3'd3,
    S_CLOSE    = 3'd4,
    S_COOLDOWN = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The counter never needs to go past the longest timed interval; capping it
  // there keeps it from wrapping in any state that does not use it.
  localparam int TICK_MAX = max2(max2(DEBOUNCE_TICKS, SETTLE_TICKS),
                                 max2(MAX_RUN_TICKS, COOLDOWN_TICKS));

  localparam logic [CNT_W-1:0] CNT_CAP    = CNT_W'(TICK_MAX - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] SET_LAST   = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_TICKS - 1);
`ifdef IRRIGATION_RUN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(MAX_RUN_TICKS - 1);
`endif

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
  logic             mode_nxt;
  logic             timed;
  logic             valve_q;
  logic             dripper_q;
  logic             sprinkler_q;
  logic             busy_q;
  logic             fault_q;

  // Next-state and mode-latch decision; a sensor conflict overrides everything.
  always_comb begin
    state_nxt = state_q;
    mode_nxt  = mode_q;
    if (bus.water_sensor_conflicting) begin
      state_nxt = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.irrigation_ok) state_nxt = S_QUALIFY;
        end
        S_QUALIFY: begin
          if (!bus.irrigation_ok) begin
            state_nxt = S_IDLE;
          end else if (bus.tick && cnt_q == DEB_LAST) begin
            state_nxt = S_OPEN;
            mode_nxt  = bus.sprinkler_mode;
          end
        end
        S_OPEN: begin
          if (bus.tick && cnt_q == SET_LAST) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!bus.irrigation_ok) state_nxt = S_CLOSE;
`ifdef IRRIGATION_RUN_TIMEOUT_EN
          else if (bus.tick && cnt_q == RUN_LAST) state_nxt = S_CLOSE;
`endif
        end
        S_CLOSE: begin
          if (bus.tick && cnt_q == SET_LAST) state_nxt = S_COOLDOWN;
        end
        S_COOLDOWN: begin
          if (bus.tick && cnt_q == COOL_LAST) state_nxt = S_IDLE;
        end
        S_FAULT: begin
          if (bus.tick) state_nxt = S_COOLDOWN;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // States in which the shared tick counter advances.
  always_comb begin
    timed = 1'b0;
    case (state_q)
      S_QUALIFY, S_OPEN, S_CLOSE, S_COOLDOWN: timed = 1'b1;
`ifdef IRRIGATION_RUN_TIMEOUT_EN
      S_RUN: timed = 1'b1;
`endif
      default: timed = 1'b0;
    endcase
  end

  // State, counter, mode and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      valve_q     <= 1'b0;
      dripper_q   <= 1'b0;
      sprinkler_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      mode_q  <= mode_nxt;
      if (state_nxt != state_q) begin
        cnt_q <= '0;
      end else if (bus.tick && timed && cnt_q != CNT_CAP) begin
        cnt_q <= cnt_q + 1'b1;
      end
      valve_q     <= (state_nxt == S_OPEN) || (state_nxt == S_RUN) ||
                     (state_nxt == S_CLOSE);
      dripper_q   <= (state_nxt == S_RUN) && !mode_nxt;
      sprinkler_q <= (state_nxt == S_RUN) && mode_nxt;
      busy_q      <= (state_nxt != S_IDLE);
      fault_q     <= (state_nxt == S_FAULT);
    end
  end

  assign bus.state        = state_q;
  assign bus.valve_open   = valve_q;
  assign bus.dripper_on   = dripper_q;
  assign bus.sprinkler_on = sprinkler_q;
  assign bus.busy         = busy_q;
  assign bus.fault        = fault_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Bench for irrigation_sequencer: directed vector table, hand-written reset
// and timeout sequences, then randomized traffic against a tick-countdown
// reference model.
module tb_irrigation_sequencer;

  localparam int P_IDLE = 0, P_QUAL = 1, P_OPEN = 2, P_RUN = 3;
  localparam int P_CLOSE = 4, P_COOL = 5, P_FAULT = 6;

  // {valve, dripper, sprinkler, busy, fault}
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_QUAL  = 5'b00010;
  localparam logic [4:0] O_OPEN  = 5'b10010;
  localparam logic [4:0] O_RUND  = 5'b11010;
  localparam logic [4:0] O_RUNS  = 5'b10110;
  localparam logic [4:0] O_CLOSE = 5'b10010;
  localparam logic [4:0] O_COOL  = 5'b00010;
  localparam logic [4:0] O_FAULT = 5'b00011;

  typedef struct {
    logic       ok;
    logic       cf;
    logic       tk;
    logic       md;
    logic [2:0] st;
    logic [4:0] o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  vec_t vecs[$];

  // Reference model: current phase and ticks still needed before leaving it.
  int   m_ph = P_IDLE;
  int   m_left = 0;
  logic m_mode = 1'b0;

  irrigation_sequencer_if bus();

  irrigation_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int p);
    case (p)
      P_QUAL:          return 4;
      P_OPEN, P_CLOSE: return 2;
      P_RUN:           return 60;
      P_COOL:          return 10;
      default:         return 0;
    endcase
  endfunction

  task automatic enter(input int p);
    m_ph   = p;
    m_left = dur(p);
  endtask

  // Consume one tick of the current interval; true when the interval is over.
  function automatic bit spend();
    m_left = m_left - 1;
    return (m_left == 0);
  endfunction

  task automatic model_reset();
    m_ph   = P_IDLE;
    m_left = 0;
    m_mode = 1'b0;
  endtask

  task automatic model_edge(input logic ok, input logic cf, input logic tk, input logic md);
    if (cf) begin
      if (m_ph != P_FAULT) enter(P_FAULT);
    end else begin
      case (m_ph)
        P_IDLE: if (ok) enter(P_QUAL);
        P_QUAL: begin
          if (!ok) enter(P_IDLE);
          else if (tk && spend()) begin
            m_mode = md;
            enter(P_OPEN);
          end
        end
        P_OPEN:  if (tk && spend()) enter(P_RUN);
        P_RUN: begin
          if (!ok) enter(P_CLOSE);
`ifdef IRRIGATION_RUN_TIMEOUT_EN
          else if (tk && spend()) enter(P_CLOSE);
`endif
        end
        P_CLOSE: if (tk && spend()) enter(P_COOL);
        P_COOL:  if (tk && spend()) enter(P_IDLE);
        P_FAULT: if (tk) enter(P_COOL);
        default: enter(P_IDLE);
      endcase
    end
  endtask

  function automatic logic [7:0] model_exp();
    logic [2:0] s;
    logic v, d, p, b, f;
    s = m_ph[2:0];
    v = (m_ph == P_OPEN) || (m_ph == P_RUN) || (m_ph == P_CLOSE);
    d = (m_ph == P_RUN) && !m_mode;
    p = (m_ph == P_RUN) && m_mode;
    b = (m_ph != P_IDLE);
    f = (m_ph == P_FAULT);
    return {s, v, d, p, b, f};
  endfunction

  function automatic logic [7:0] observed();
    return {bus.state, bus.valve_open, bus.dripper_on, bus.sprinkler_on,
            bus.busy, bus.fault};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state/outs=%b required %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic ok, input logic cf, input logic tk, input logic md);
    bus.irrigation_ok            = ok;
    bus.water_sensor_conflicting = cf;
    bus.tick                     = tk;
    bus.sprinkler_mode           = md;
  endtask

  task automatic step(input logic ok, input logic cf, input logic tk, input logic md);
    drive(ok, cf, tk, md);
    @(posedge clk);
    model_edge(ok, cf, tk, md);
    #1;
  endtask

  task automatic add(input logic ok, input logic cf, input logic tk, input logic md,
                     input int st, input logic [4:0] o);
    vec_t v;
    v.ok = ok; v.cf = cf; v.tk = tk; v.md = md; v.st = st[2:0]; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic ok, input logic cf, input logic tk,
                       input logic md, input int st, input logic [4:0] o);
    for (int k = 0; k < n; k++) add(ok, cf, tk, md, st, o);
  endtask

  initial begin
    logic ok_r;
    int   cf_left;
    int   run_len;
    bit   seen_run, left_run, requal;

    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Dripper run, tick held high, mode change mid-run ignored.
    add_n(4, 1, 0, 1, 0, P_QUAL, O_QUAL);
    add_n(2, 1, 0, 1, 0, P_OPEN, O_OPEN);
    add  (   1, 0, 1, 0, P_RUN,  O_RUND);
    add  (   1, 0, 1, 1, P_RUN,  O_RUND);
    add_n(2, 0, 0, 1, 0, P_CLOSE, O_CLOSE);
    add  (   0, 0, 1, 0, P_COOL, O_COOL);
    add_n(9, 0, 0, 1, 0, P_COOL, O_COOL);
    add  (   0, 0, 1, 0, P_IDLE, O_IDLE);
    // Permission lost after 3 qualification ticks, dropping on a tick.
    add_n(4, 1, 0, 1, 0, P_QUAL, O_QUAL);
    add  (   0, 0, 1, 0, P_IDLE, O_IDLE);
    // Sprinkler run with sparse ticks; ok ignored during cooldown.
    add  (   1, 0, 0, 0, P_QUAL, O_QUAL);
    add_n(3, 1, 0, 1, 0, P_QUAL, O_QUAL);
    add  (   1, 0, 0, 0, P_QUAL, O_QUAL);
    add  (   1, 0, 1, 1, P_OPEN, O_OPEN);
    add  (   1, 0, 1, 0, P_OPEN, O_OPEN);
    add  (   1, 0, 0, 0, P_OPEN, O_OPEN);
    add  (   1, 0, 1, 0, P_RUN,  O_RUNS);
    add  (   1, 0, 1, 0, P_RUN,  O_RUNS);
    add  (   0, 0, 0, 0, P_CLOSE, O_CLOSE);
    add  (   0, 0, 1, 0, P_CLOSE, O_CLOSE);
    add  (   0, 0, 1, 0, P_COOL, O_COOL);
    add_n(9, 1, 0, 1, 0, P_COOL, O_COOL);
    add  (   0, 0, 1, 0, P_IDLE, O_IDLE);
    // Conflict during RUN, then cleared without and with a tick.
    add_n(4, 1, 0, 1, 0, P_QUAL, O_QUAL);
    add_n(2, 1, 0, 1, 0, P_OPEN, O_OPEN);
    add  (   1, 0, 1, 0, P_RUN,  O_RUND);
    add_n(2, 1, 1, 1, 0, P_FAULT, O_FAULT);
    add  (   1, 0, 0, 0, P_FAULT, O_FAULT);
    add  (   1, 0, 1, 0, P_COOL, O_COOL);
    add_n(9, 1, 0, 1, 0, P_COOL, O_COOL);
    add  (   0, 0, 1, 0, P_IDLE, O_IDLE);
    // Conflict from IDLE and again during cooldown.
    add  (   0, 1, 0, 0, P_FAULT, O_FAULT);
    add  (   0, 0, 1, 0, P_COOL, O_COOL);
    add  (   0, 1, 1, 0, P_FAULT, O_FAULT);
    add  (   0, 0, 1, 0, P_COOL, O_COOL);
    add_n(9, 0, 0, 1, 0, P_COOL, O_COOL);
    add  (   0, 0, 1, 0, P_IDLE, O_IDLE);
    // Conflict on the very edge qualification would complete.
    add_n(4, 1, 0, 1, 0, P_QUAL, O_QUAL);
    add  (   1, 1, 1, 0, P_FAULT, O_FAULT);
    add  (   0, 0, 1, 0, P_COOL, O_COOL);
    add_n(9, 0, 0, 1, 0, P_COOL, O_COOL);
    add  (   0, 0, 1, 0, P_IDLE, O_IDLE);

    // Asynchronous reset, observed before any clock edge.
    #1 rst_n = 1'b0;
    #2 check("reset_state", observed(), 8'h00);
    #9 rst_n = 1'b1;
    model_reset();

    foreach (vecs[i]) begin
      step(vecs[i].ok, vecs[i].cf, vecs[i].tk, vecs[i].md);
      check($sformatf("vec%0d", i), observed(), {vecs[i].st, vecs[i].o});
    end

    // Reset asserted in RUN drops everything without waiting for a clock.
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      check("to_run", observed(), model_exp());
    end
    check("in_run", observed(), {3'd3, O_RUNS});
    #3 rst_n = 1'b0;
    #1 check("reset_mid_run", observed(), 8'h00);
    #1 rst_n = 1'b1;
    model_reset();

`ifdef IRRIGATION_RUN_TIMEOUT_EN
    // Permission held: run ends on the limit, then requalifies after cooldown.
    run_len = 0; seen_run = 0; left_run = 0; requal = 0;
    for (int k = 0; k < 200 && !requal; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("timeout_seq", observed(), model_exp());
      if (bus.state == 3'd3 && !left_run) begin
        seen_run = 1;
        run_len++;
      end else if (seen_run && !left_run) begin
        left_run = 1;
      end else if (left_run && bus.state == 3'd1) begin
        requal = 1;
      end
    end
    check("timeout_run_len", 8'(run_len), 8'd60);
    check("timeout_requal", {7'd0, requal}, 8'd1);
`else
    run_len = 0; seen_run = 0; left_run = 0; requal = 0;
`endif

    // Randomized traffic against the reference model.
    ok_r = 1'b0;
    cf_left = 0;
    for (int k = 0; k < 4000; k++) begin
      logic cf;
      if ($urandom_range(19) == 0) ok_r = ~ok_r;
      if (cf_left > 0) begin
        cf = 1'b1;
        cf_left--;
      end else begin
        cf = 1'b0;
        if ($urandom_range(149) == 0) cf_left = $urandom_range(3, 1);
      end
      step(ok_r, cf, 1'($urandom_range(1)), 1'($urandom_range(1)));
      check("random", observed(), model_exp());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
# irrigation_sequencer

Sequences the irrigation actuators from the single-bit irrigation permission produced by the irrigation prerequisite check. Qualifies the permission over several time ticks. Opens the supply valve and lets it settle before enabling the dripper or the sprinkler. Drains and cools down after every run. Forces a safe all-off fault state whenever the water sensors conflict. Sits between the combinational prerequisite logic and the actuator drivers.

## Interface
- DEBOUNCE_TICKS, 4: consecutive ticks `irrigation_ok` must hold before the valve opens (≥1).
- SETTLE_TICKS, 2: ticks spent in OPEN and in CLOSE (≥1).
- MAX_RUN_TICKS, 60: run limit; used only when the timeout macro is defined (≥1).
- COOLDOWN_TICKS, 10: ticks of forced idle after a run or a fault (≥1).
- CNT_W, 8: tick counter width; must hold the largest tick parameter minus 1.

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle time-base strobe; all timing is counted in ticks.
- `irrigation_ok`  in  1  permission from the prerequisite logic (dry earth, no conflict, water not critical).
- `water_sensor_conflicting`  in  1  water-level sensor conflict flag.
- `sprinkler_mode`  in  1  0 = dripper, 1 = sprinkler; sampled on entry to OPEN.
- `valve_open`  out  1  supply valve command.
- `dripper_on`  out  1  dripper enable.
- `sprinkler_on`  out  1  sprinkler enable.
- `busy`  out  1  high in every state except IDLE.
- `fault`  out  1  high in FAULT only.
- `state`  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, QUALIFY=1, OPEN=2, RUN=3, CLOSE=4, COOLDOWN=5, FAULT=6; code 7 is illegal and recovers to IDLE on the next edge.
- One shared tick counter; it is cleared on every state entry and increments on `tick` while in a timed state.
- "N ticks elapse" means `tick`=1 while the counter equals N-1. The transition takes effect at that edge.
- IDLE → QUALIFY when `irrigation_ok`=1.
- QUALIFY → IDLE on any cycle with `irrigation_ok`=0.
- QUALIFY → OPEN when DEBOUNCE_TICKS elapse. `sprinkler_mode` is latched into the mode register at this edge.
- OPEN → RUN when SETTLE_TICKS elapse. Drops in `irrigation_ok` are ignored while in OPEN.
- RUN → CLOSE on any cycle with `irrigation_ok`=0.
- CLOSE → COOLDOWN when SETTLE_TICKS elapse.
- COOLDOWN → IDLE when COOLDOWN_TICKS elapse. `irrigation_ok` is ignored while in COOLDOWN.
- Any state → FAULT when `water_sensor_conflicting`=1. This has priority over all other transitions, including in IDLE.
- FAULT → COOLDOWN at the first `tick` with `water_sensor_conflicting`=0.
- Moore outputs, decoded from the state and mode registers only:
  - `valve_open`=1 in OPEN, RUN and CLOSE.
  - `dripper_on` = RUN & !mode.
  - `sprinkler_on` = RUN & mode.
  - `dripper_on` and `sprinkler_on` are never high together.
- Mid-run changes to `sprinkler_mode` have no effect until the next OPEN entry.

## Timing
- Reset (`rst_n`=0) takes effect immediately, without a clock edge:
  - state=IDLE, counter=0, mode=0.
  - All outputs 0.
- Reset asserted mid-run drops the actuators and the valve at once.
- Transition latency: the state register updates on the edge where its condition is true. Outputs follow in the same cycle after that edge; there is no extra pipeline stage.
- With `tick` held at 1, from the edge where `irrigation_ok` first rises:
  - 1 cycle to QUALIFY.
  - DEBOUNCE_TICKS cycles in QUALIFY.
  - SETTLE_TICKS cycles in OPEN, then RUN.
- A `tick` on a state-entry edge is not counted; the counter starts at 0 in the new state.
- Simultaneous conflict and any exit condition: FAULT wins.
- `tick` and `irrigation_ok`=0 in the same QUALIFY cycle: the block goes to IDLE.

## Configuration
- `IRRIGATION_RUN_TIMEOUT_EN` undefined:
  - RUN lasts until `irrigation_ok` falls or a conflict occurs.
  - MAX_RUN_TICKS is unused.
- `IRRIGATION_RUN_TIMEOUT_EN` defined:
  - RUN → CLOSE additionally when MAX_RUN_TICKS elapse.
  - If `irrigation_ok` is still 1 after the cooldown, a new qualification starts from IDLE.

## Test plan
- Reset mid-RUN → all outputs 0 and `state`=0 before the next clock edge.
- Defaults, `tick`=1, `sprinkler_mode`=0, raise `irrigation_ok` → `valve_open` at cycle 5; `dripper_on` at cycle 7; `sprinkler_on` stays 0.
- `irrigation_ok` pulses high for 3 ticks in QUALIFY, then drops → return to IDLE; `valve_open` never asserts.
- In RUN with `sprinkler_mode`=1 latched, drop `irrigation_ok` → `sprinkler_on` drops next edge; `valve_open` holds 2 ticks; `busy` then clears after 10 more ticks.
- Assert `water_sensor_conflicting` in RUN → FAULT next edge, all actuators 0, `fault`=1. Deassert it → COOLDOWN at the next tick, then IDLE after 10 ticks.
- With `IRRIGATION_RUN_TIMEOUT_EN` defined and `irrigation_ok` held at 1 → RUN ends after 60 ticks, followed by CLOSE, COOLDOWN, then requalification.
